// File: rtl/dmt_pkg.sv
// Shared DMT transmit-path definitions.
// Holds carrier/constellation widths, read-FSM state type, the output
// sample struct and the gain saturation helper used by tone_symbol_buffer.
package dmt_pkg;

  localparam int CNUMW    = 8;    // carrier number width
  localparam int CONSTW   = 15;   // signed x/y width
  localparam int NCARR    = 256;  // carriers per symbol (<= 2**CNUMW)
  localparam int GAINW    = 12;   // unsigned gain word width
  localparam int GAINFRAC = 9;    // gain fraction bits

  localparam int XYW   = 2 * CONSTW;          // packed {x,y} word
  localparam int PRODW = CONSTW + GAINW + 1;  // x * {0,gain} product

  localparam logic [GAINW-1:0] GAIN_ONE = GAINW'(1 << GAINFRAC);

  localparam logic signed [PRODW-1:0] SAT_MAX = PRODW'((1 << (CONSTW - 1)) - 1);
  localparam logic signed [PRODW-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {
    RD_IDLE,    // nothing to stream
    RD_STREAM,  // still fetching carriers from the read bank
    RD_DRAIN    // last carrier fetched, waiting for it to be accepted
  } rd_state_e;

  typedef struct packed {
    logic [CNUMW-1:0]         carrier;
    logic signed [CONSTW-1:0] x;
    logic signed [CONSTW-1:0] y;
  } sample_t;

  // Drop the gain fraction bits, then clamp into CONSTW signed range.
  function automatic logic signed [CONSTW-1:0] saturate(input logic signed [PRODW-1:0] v);
    logic signed [PRODW-1:0] s;
    s = v >>> GAINFRAC;
    if (s > SAT_MAX)      saturate = SAT_MAX[CONSTW-1:0];
    else if (s < SAT_MIN) saturate = SAT_MIN[CONSTW-1:0];
    else                  saturate = s[CONSTW-1:0];
  endfunction

endpackage

// File: rtl/sym_bank.sv
// One bank of the symbol ping-pong buffer.
// Ports: we_i/waddr_i/wdata_i write a {x,y} word and mark the carrier loaded;
// clr_i clears the whole loaded bitmap in one cycle; re_i/raddr_i load the
// registered read port rdata_o, which returns 0 for unloaded carriers.
// A read and write to the same address in one cycle returns the new data.
module sym_bank
  import dmt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [CNUMW-1:0] waddr_i,
  input  logic [XYW-1:0]   wdata_i,
  input  logic             clr_i,
  input  logic             re_i,
  input  logic [CNUMW-1:0] raddr_i,
  output logic [XYW-1:0]   rdata_o
);

  logic [XYW-1:0]   mem_q [NCARR];
  logic [NCARR-1:0] loaded_q;
  logic [XYW-1:0]   rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (clr_i) loaded_q <= '0;
      if (we_i)  loaded_q[waddr_i] <= 1'b1;
      if (re_i) begin
        // bypass lets a point written in the closing cycle reach carrier 0
        if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
        else if (loaded_q[raddr_i])       rdata_q <= mem_q[raddr_i];
        else                              rdata_q <= '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tone_symbol_buffer.sv
// Ping-pong tone buffer between const_encoder and the IFFT.
// Collects (carrier, x, y) points of a DMT symbol into the write bank, and on
// sym_done_i swaps banks and streams carriers 0..NCARR-1 with valid/ready,
// zero-filling unloaded carriers.
// Ports: clk, reset (async high); xy_ready_i/carrier_num_i/x_i/y_i point in;
// sym_done_i symbol close; out_valid_o/out_ready_i/out_carrier_o/out_x_o/
// out_y_o/out_last_o sample stream; overflow_o sticky close-while-busy flag.
// Optional macro GAIN_SCALE_EN adds we_gain_i/gain_addr_i/gain_data_i and a
// per-carrier saturating gain stage (one extra output register).
module tone_symbol_buffer
  import dmt_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xy_ready_i,
  input  logic [CNUMW-1:0]         carrier_num_i,
  input  logic signed [CONSTW-1:0] x_i,
  input  logic signed [CONSTW-1:0] y_i,
  input  logic                     sym_done_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CNUMW-1:0]         out_carrier_o,
  output logic signed [CONSTW-1:0] out_x_o,
  output logic signed [CONSTW-1:0] out_y_o,
  output logic                     out_last_o,
  output logic                     overflow_o
`ifdef GAIN_SCALE_EN
  ,
  input  logic                     we_gain_i,
  input  logic [CNUMW-1:0]         gain_addr_i,
  input  logic [GAINW-1:0]         gain_data_i
`endif
);

  logic             wb_q, wb_d, rb_q, rb_d;
  rd_state_e        state_q, state_d;
  logic [CNUMW-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  // head stage: sample whose data sits in the bank read register
  logic             hd_valid_q, hd_valid_d, hd_last_q, hd_last_d;
  logic [CNUMW-1:0] hd_carrier_q, hd_carrier_d;

  logic             wr_ok, last_acc, rd_idle, swap, free_hd, stream_load, load, src;
  logic [CNUMW-1:0] raddr;
  logic [1:0][XYW-1:0] bank_rd;
  sample_t          hd_s;

  assign wr_ok    = xy_ready_i && ({1'b0, carrier_num_i} < (CNUMW + 1)'(NCARR));
  assign last_acc = out_valid_o && out_ready_i && out_last_o;
  // the cycle that retires the last sample already counts as idle
  assign rd_idle  = (state_q == RD_IDLE) || last_acc;
  assign swap     = sym_done_i && rd_idle;
  assign stream_load = (state_q == RD_STREAM) && free_hd;
  assign load     = swap || stream_load;
  assign hd_s     = {hd_carrier_q, bank_rd[rb_q]};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sym_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_ok && (wb_q == 1'(b))),
      .waddr_i (carrier_num_i),
      .wdata_i ({x_i, y_i}),
      .clr_i   (swap && (wb_q != 1'(b))),
      .re_i    (load && (src == 1'(b))),
      .raddr_i (raddr),
      .rdata_o (bank_rd[b])
    );
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    ovf_d        = ovf_q;
    hd_valid_d   = hd_valid_q;
    hd_last_d    = hd_last_q;
    hd_carrier_d = hd_carrier_q;
    raddr        = rd_ptr_q;
    src          = rb_q;

    if (sym_done_i && !rd_idle) ovf_d = 1'b1;

    if (swap) begin
      // carrier 0 is fetched straight from the closing bank in the swap cycle
      rb_d         = wb_q;
      wb_d         = ~wb_q;
      src          = wb_q;
      raddr        = '0;
      rd_ptr_d     = CNUMW'(1);
      state_d      = (NCARR == 1) ? RD_DRAIN : RD_STREAM;
      hd_valid_d   = 1'b1;
      hd_carrier_d = '0;
      hd_last_d    = (NCARR == 1);
    end else if (stream_load) begin
      hd_valid_d   = 1'b1;
      hd_carrier_d = rd_ptr_q;
      hd_last_d    = (rd_ptr_q == CNUMW'(NCARR - 1));
      rd_ptr_d     = rd_ptr_q + CNUMW'(1);
      if (rd_ptr_q == CNUMW'(NCARR - 1)) state_d = RD_DRAIN;
    end else begin
      if (free_hd) begin
        hd_valid_d = 1'b0;
        hd_last_d  = 1'b0;
      end
      if (last_acc) state_d = RD_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RD_IDLE;
      rd_ptr_q     <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      ovf_q        <= 1'b0;
      hd_valid_q   <= 1'b0;
      hd_last_q    <= 1'b0;
      hd_carrier_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      ovf_q        <= ovf_d;
      hd_valid_q   <= hd_valid_d;
      hd_last_q    <= hd_last_d;
      hd_carrier_q <= hd_carrier_d;
    end
  end

  assign overflow_o = ovf_q;

`ifdef GAIN_SCALE_EN
  logic [GAINW-1:0]        gain_q [NCARR];
  logic [GAINW-1:0]        gain_rd_q;
  logic                    out_valid_q, out_last_q;
  sample_t                 out_q;
  logic signed [PRODW-1:0] prod_x, prod_y;

  assign free_hd = !hd_valid_q || !out_valid_q || out_ready_i;
  assign prod_x  = hd_s.x * $signed({1'b0, gain_rd_q});
  assign prod_y  = hd_s.y * $signed({1'b0, gain_rd_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCARR; i++) gain_q[i] <= GAIN_ONE;
      gain_rd_q <= GAIN_ONE;
    end else begin
      if (we_gain_i && ({1'b0, gain_addr_i} < (CNUMW + 1)'(NCARR)))
        gain_q[gain_addr_i] <= gain_data_i;
      // gain fetched alongside the bank read so both land in the head stage
      if (load) gain_rd_q <= gain_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
    end else if (!out_valid_q || out_ready_i) begin
      out_valid_q <= hd_valid_q;
      out_last_q  <= hd_last_q;
      out_q       <= '{carrier: hd_s.carrier, x: saturate(prod_x), y: saturate(prod_y)};
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_last_o    = out_last_q;
  assign out_carrier_o = out_q.carrier;
  assign out_x_o       = out_q.x;
  assign out_y_o       = out_q.y;
`else
  assign free_hd       = !hd_valid_q || out_ready_i;
  assign out_valid_o   = hd_valid_q;
  assign out_last_o    = hd_last_q;
  assign out_carrier_o = hd_s.carrier;
  assign out_x_o       = hd_s.x;
  assign out_y_o       = hd_s.y;
`endif

endmodule

// File: tb/tb_tone_symbol_buffer.sv
// Self-checking bench for tone_symbol_buffer (default build).
// A reference model of the write bank is snapshotted into a scoreboard queue
// whenever a symbol close is expected to swap; the monitor pops and compares
// every accepted sample and checks that stalled outputs hold.
module tb_tone_symbol_buffer;

  localparam int NC = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              xy_ready_i;
  logic [7:0]        carrier_num_i;
  logic signed [14:0] x_i, y_i;
  logic              sym_done_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [7:0]        out_carrier_o;
  logic signed [14:0] out_x_o, out_y_o;
  logic              out_last_o;
  logic              overflow_o;

  always #5 clk = ~clk;

  tone_symbol_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .xy_ready_i    (xy_ready_i),
    .carrier_num_i (carrier_num_i),
    .x_i           (x_i),
    .y_i           (y_i),
    .sym_done_i    (sym_done_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_carrier_o (out_carrier_o),
    .out_x_o       (out_x_o),
    .out_y_o       (out_y_o),
    .out_last_o    (out_last_o),
    .overflow_o    (overflow_o)
  );

  typedef struct packed {
    logic [7:0]         c;
    logic signed [14:0] x;
    logic signed [14:0] y;
    logic               last;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [14:0] mx[NC];
  logic signed [14:0] my[NC];
  bit                 mv[NC];
  int                 checks = 0;
  int                 errors = 0;
  int                 acc_cnt = 0;
  bit                 stalled = 0;
  logic [39:0]        hold;

  // scoreboard monitor + stall stability
  always @(negedge clk) begin
    exp_t e, got;
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checks++;
        if ({out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o} !== hold) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h",
                   {out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o}, hold);
        end
      end
      if (out_valid_o && out_ready_i) begin
        got = '{out_carrier_o, out_x_o, out_y_o, out_last_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got c=%0d x=%0d y=%0d, expected none",
                   out_carrier_o, out_x_o, out_y_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sample: got c=%0d x=%0d y=%0d last=%0b expected c=%0d x=%0d y=%0d last=%0b",
                     got.c, got.x, got.y, got.last, e.c, e.x, e.y, e.last);
          end
        end
        acc_cnt++;
        stalled = 0;
      end else if (out_valid_o) begin
        stalled = 1;
        hold = {out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o};
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) mv[i] = 0;
  endtask

  // snapshot of the write-bank model = the symbol the DUT must stream next
  task automatic push_symbol();
    for (int i = 0; i < NC; i++)
      exp_q.push_back('{8'(i), mv[i] ? mx[i] : 15'sd0, mv[i] ? my[i] : 15'sd0, i == NC - 1});
    model_clear();
  endtask

  task automatic write_point(input int c, input int x, input int y);
    xy_ready_i = 1; carrier_num_i = 8'(c); x_i = 15'(x); y_i = 15'(y);
    mx[c] = 15'(x); my[c] = 15'(y); mv[c] = 1;
    cyc();
    xy_ready_i = 0;
  endtask

  task automatic close_sym(input bit wr, input int c, input int x, input int y);
    sym_done_i = 1;
    if (wr) begin
      xy_ready_i = 1; carrier_num_i = 8'(c); x_i = 15'(x); y_i = 15'(y);
      mx[c] = 15'(x); my[c] = 15'(y); mv[c] = 1;
    end
    push_symbol();
    cyc();
    sym_done_i = 0;
    xy_ready_i = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid_o) begin
      errors++;
      $display("FAIL %s_drain: got %0d samples outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 0;
    #2 reset = 1;
    #1;
    checks++;
    if ({out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o, overflow_o} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b c=%0d x=%0d y=%0d last=%0b ovf=%0b expected all 0",
               out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o, overflow_o);
    end
    cyc(); cyc();
    reset = 0;
    repeat (2) cyc();
    checks++;
    if (out_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got v=%0b ovf=%0b expected 0 0", out_valid_o, overflow_o);
    end
  endtask

  task automatic test_basic();
    write_point(48, 1, 1);
    write_point(49, -1, 1);
    write_point(50, 3, -3);
    write_point(51, -5, 5);
    close_sym(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b1 || out_carrier_o !== 8'd0) begin
      errors++;
      $display("FAIL basic_latency: got v=%0b c=%0d expected v=1 c=0", out_valid_o, out_carrier_o);
    end
    wait_drain("basic", 600);
  endtask

  task automatic test_backpressure();
    int a0, n;
    write_point(0, 77, -1);
    write_point(128, -16384, 16383);
    write_point(255, 9, 9);
    a0 = acc_cnt;
    close_sym(0, 0, 0, 0);
    n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 2000) begin
      cyc();
      out_ready_i = ~out_ready_i;
      n++;
    end
    out_ready_i = 1;
    @(negedge clk);
    checks++;
    if (acc_cnt - a0 != NC || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d accepted expected %0d", acc_cnt - a0, NC);
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    write_point(200, 4, 4);
    close_sym(1, 10, 7, -2);
    wait_drain("simul", 600);
    close_sym(0, 0, 0, 0);   // new write bank must stream all zeros
    wait_drain("simul_empty", 600);
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    write_point(3, 100, -100);
    close_sym(0, 0, 0, 0);
    write_point(200, -7, 8);
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (out_valid_o && out_last_o && out_ready_i) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_last: got no last sample expected one within 600 cycles");
    end
    sym_done_i = 1;
    push_symbol();
    @(posedge clk);
    #1 sym_done_i = 0;
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b1 || out_carrier_o !== 8'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gapless: got v=%0b c=%0d ovf=%0b expected v=1 c=0 ovf=0",
               out_valid_o, out_carrier_o, overflow_o);
    end
    wait_drain("b2b", 600);
  endtask

  task automatic test_overflow();
    bit seen = 0;
    write_point(5, 2, 3);
    close_sym(0, 0, 0, 0);
    repeat (20) cyc();
    write_point(7, 9, -9);
    sym_done_i = 1;            // rejected close: no snapshot pushed
    cyc();
    sym_done_i = 0;
    @(negedge clk);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %0b expected 1", overflow_o);
    end
    wait_drain("ovf_first", 600);
    repeat (5) begin
      @(negedge clk);
      if (out_valid_o) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL overflow_noswap: got valid=1 expected 0 while idle");
    end
    close_sym(0, 0, 0, 0);
    wait_drain("ovf_second", 600);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %0b expected 1", overflow_o);
    end
  endtask

  task automatic test_reset_mid();
    int a0, n;
    write_point(100, 55, -55);
    a0 = acc_cnt;
    close_sym(0, 0, 0, 0);
    n = 0;
    while (acc_cnt - a0 < 100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o, overflow_o} !== 41'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%0b c=%0d x=%0d y=%0d last=%0b ovf=%0b expected all 0",
               out_valid_o, out_carrier_o, out_x_o, out_y_o, out_last_o, overflow_o);
    end
    exp_q.delete();
    model_clear();
    cyc(); cyc();
    reset = 0;
    write_point(0, 11, -11);
    close_sym(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b1 || out_carrier_o !== 8'd0 || out_x_o !== 15'sd11) begin
      errors++;
      $display("FAIL midreset_restart: got v=%0b c=%0d x=%0d expected v=1 c=0 x=11",
               out_valid_o, out_carrier_o, out_x_o);
    end
    wait_drain("midreset", 600);
  endtask

  initial begin
    xy_ready_i = 0; carrier_num_i = 0; x_i = 0; y_i = 0;
    sym_done_i = 0; out_ready_i = 1;
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
